alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have no parameters; data width fixed at 32, queue depth fixed at 2.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous reset, active-low, sampled on rising clock edge.
REQ-004 in_valid_rs  input  1  upstream ALU result present this cycle.
REQ-005 in_ready_rs  output  1  stage can accept an entry this cycle.
REQ-006 result_in_rs  input  32  selected ALU result from the ALU result mux.
REQ-007 opcode_in_rs  input  5  ALU opcode that drove the mux select, same cycle as result.
REQ-008 ovf_in_rs  input  1  raw adder/subtractor overflow, same cycle.
REQ-009 out_valid_rs  output  1  head entry valid.
REQ-010 out_ready_rs  input  1  downstream accepts head entry this cycle.
REQ-011 result_out_rs  output  32  head entry result.
REQ-012 zero_rs, neg_rs, ovf_rs, lt_rs, ne_rs, illegal_rs  output  1 each  head entry flags.
REQ-013 clr_ovf_cnt_rs  input  1  clear overflow event counter.
REQ-014 ovf_cnt_rs  output  8  saturating count of accepted overflowing entries.

Function
REQ-015 Accept = in_valid_rs & in_ready_rs; pop = out_valid_rs & out_ready_rs.
REQ-016 in_ready_rs SHALL be 1 iff occupancy < 2; depends on registered occupancy only, never on out_ready_rs.
REQ-017 out_valid_rs SHALL be 1 iff occupancy != 0; head outputs driven from registers only.
REQ-018 Latency: entry accepted in cycle N into empty stage SHALL appear at outputs in cycle N+1.
REQ-019 Order SHALL be FIFO; head entry and flags SHALL hold stable while out_valid_rs=1 and out_ready_rs=0.
REQ-020 Occupancy: accept only +1; pop only -1; accept and pop together unchanged (legal at occupancy 1; at 2 accept impossible; at 0 pop impossible).
REQ-021 Flags computed at accept time from the stored (post-forcing) result and opcode[2:0]: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 sra, 11x illegal; opcode[4:3] ignored.
REQ-022 Illegal opcode: entry accepted, stored result forced to 0, illegal=1, other flags computed from the zero result.
REQ-023 zero = (result == 0); neg = result[31].
REQ-024 ovf = ovf_in_rs for add/sub, else 0.
REQ-025 lt = result[31] XOR ovf_in_rs for sub only, else 0; ne = (result != 0) for sub only, else 0.
REQ-026 ovf_cnt_rs increments by 1 per accepted entry with ovf=1, saturating at 255.
REQ-027 clr_ovf_cnt_rs with simultaneous counted accept SHALL yield ovf_cnt_rs = 1; clear alone yields 0.
REQ-028 Inputs SHALL be ignored when in_ready_rs=0; no X propagation from unaccepted inputs into outputs.

Reset
REQ-029 While reset_n=0 at a clock edge: occupancy 0, out_valid_rs 0, in_ready_rs 1 next cycle, result_out_rs 0, all flags 0, ovf_cnt_rs 0.
REQ-030 Reset mid-operation SHALL discard all queued entries; accept/pop in the reset cycle has no effect.

Verification
REQ-031 Empty stage, accept add result 0x00000005 (ovf 0), out_ready=1 -> next cycle out_valid=1, result 0x5, all flags 0; following cycle out_valid=0.
REQ-032 Sub result 0x80000000 with ovf_in=1 -> ovf=1, neg=1, lt=0, ne=1, ovf_cnt 0->1.
REQ-033 out_ready=0, push 3 entries back-to-back -> first two accepted, in_ready=0 in third cycle, third held; release -> outputs in order 1,2 then third accepted.
REQ-034 Occupancy 1, simultaneous accept and pop over 10 cycles -> occupancy stays 1, one-cycle latency, no loss/duplication.
REQ-035 Opcode 5'b00110 with result 0x1234 -> result_out 0, illegal=1, zero=1; 300 overflowing adds -> ovf_cnt 255; clear with counted accept -> 1.
REQ-036 reset_n=0 with 2 entries queued -> next cycle out_valid=0, in_ready=1, ovf_cnt=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result stage: two-entry skid queue between the ALU result mux and
// writeback. Status flags are derived once, when an entry is accepted, and
// travel with the entry. A saturating counter tracks accepted overflows.
module alu_result_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid_rs,
  output logic        in_ready_rs,
  input  logic [31:0] result_in_rs,
  input  logic [4:0]  opcode_in_rs,
  input  logic        ovf_in_rs,
  output logic        out_valid_rs,
  input  logic        out_ready_rs,
  output logic [31:0] result_out_rs,
  output logic        zero_rs,
  output logic        neg_rs,
  output logic        ovf_rs,
  output logic        lt_rs,
  output logic        ne_rs,
  output logic        illegal_rs,
  input  logic        clr_ovf_cnt_rs,
  output logic [7:0]  ovf_cnt_rs
);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        lt;
    logic        ne;
    logic        illegal;
  } entry_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  ovf_cnt_q, ovf_cnt_d;

  entry_t      new_entry;
  logic        accept;
  logic        pop;
  logic [2:0]  op;
  logic        is_sub;
  logic        unused_opcode_hi;

  // Upper opcode bits select ALU sub-variants that do not affect flags.
  assign unused_opcode_hi = ^opcode_in_rs[4:3];

  assign op     = opcode_in_rs[2:0];
  assign is_sub = (op == OP_SUB);

  assign in_ready_rs  = (count_q != 2'd2);
  assign out_valid_rs = (count_q != 2'd0);
  assign accept       = in_valid_rs & in_ready_rs;
  assign pop          = out_valid_rs & out_ready_rs;

  // Build the stored entry: illegal opcodes force a zero result, then flags
  // are derived from the value actually stored.
  always_comb begin
    new_entry         = '0;
    new_entry.illegal = (op[2:1] == 2'b11);
    new_entry.result  = new_entry.illegal ? 32'd0 : result_in_rs;
    new_entry.zero    = (new_entry.result == 32'd0);
    new_entry.neg     = new_entry.result[31];
    new_entry.ovf     = ((op == OP_ADD) || is_sub) ? ovf_in_rs : 1'b0;
    new_entry.lt      = is_sub ? (new_entry.result[31] ^ ovf_in_rs) : 1'b0;
    new_entry.ne      = is_sub ? (new_entry.result != 32'd0) : 1'b0;
  end

  // Queue update: head always holds the oldest entry so outputs come
  // straight from head_q; a pop shifts the tail entry forward.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = new_entry;
        else                 tail_d = new_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at occupancy 1: the sole entry leaves, the new one
        // becomes head.
        head_d = new_entry;
      end
      default: ;
    endcase
  end

  // Overflow event counter: clear wins over the old value but not over a
  // same-cycle counted accept.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_ovf_cnt_rs) begin
      ovf_cnt_d = (accept && new_entry.ovf) ? 8'd1 : 8'd0;
    end else if (accept && new_entry.ovf && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      ovf_cnt_q <= 8'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign result_out_rs = head_q.result;
  assign zero_rs       = head_q.zero;
  assign neg_rs        = head_q.neg;
  assign ovf_rs        = head_q.ovf;
  assign lt_rs         = head_q.lt;
  assign ne_rs         = head_q.ne;
  assign illegal_rs    = head_q.illegal;
  assign ovf_cnt_rs    = ovf_cnt_q;

endmodule
